// File: rtl/dcache_controller_pkg.sv
// Shared types and default geometry for the data cache sequencing controller.
package dcache_ctrl_pkg;

   localparam int DC_SIZE       = 256;
   localparam int DC_INDEX_BITS = 8;

   typedef enum logic [2:0] {
      DC_IDLE       = 3'd0,
      DC_WRITEBACK  = 3'd1,
      DC_ALLOCATE   = 3'd2,
      DC_FLUSH_SCAN = 3'd3,
      DC_FLUSH_WB   = 3'd4,
      DC_FLUSH_DONE = 3'd5
   } dc_state_e;

endpackage

// File: rtl/dcache_controller_if.sv
// Request/acknowledge handshake between the data cache controller and the bus/memory side.
interface dcache_controller_if;

   logic dcache2mem_req_o;
   logic dcache2mem_wr_o;
   logic mem2dcache_ack_i;

   modport master (
      output dcache2mem_req_o,
      output dcache2mem_wr_o,
      input  mem2dcache_ack_i
   );

   modport slave (
      input  dcache2mem_req_o,
      input  dcache2mem_wr_o,
      output mem2dcache_ack_i
   );

endinterface

// File: rtl/dcache_controller.sv
// Miss/flush sequencer: turns CPU misses into writeback + allocate bus handshakes and
// walks the dirty vector on flush, writing back each dirty line in ascending index order.
module dcache_controller
   import dcache_ctrl_pkg::*;
#(
   parameter int SIZE       = DC_SIZE,
   parameter int INDEX_BITS = DC_INDEX_BITS
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  read_en,
   input  logic                  write_en,
   input  logic [INDEX_BITS-1:0] req_index_i,
   input  logic                  cache_hit_i,
   input  logic                  cache_evict_req_i,
   input  logic                  cache_flush_i,
   input  logic [SIZE-1:0]       dirty_vector,
   dcache_controller_if.master   bus,
   output logic                  cache_line_wr_o,
   output logic                  cache_wrb_req_o,
   output logic                  cache_line_clean_o,
   output logic [INDEX_BITS-1:0] evict_index_o,
   output logic                  cpu_stall_o,
   output logic                  flush_done_o
);

   localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(SIZE - 1);
   localparam logic [INDEX_BITS-1:0] IDX_ZERO = INDEX_BITS'(0);
   localparam logic [INDEX_BITS-1:0] IDX_ONE  = INDEX_BITS'(1);

   dc_state_e             r_state;
   dc_state_e             w_next_state;
   logic [INDEX_BITS-1:0] r_flush_idx;
   logic [INDEX_BITS-1:0] w_next_idx;
   logic                  w_req;
   logic                  w_wr;
   logic                  w_wrb;
   logic                  w_line_wr;
   logic                  w_clean;
   logic                  w_stall;
   logic                  w_done;
   logic [INDEX_BITS-1:0] w_evict_idx;
   logic                  w_cpu_req;

   assign w_cpu_req = read_en | write_en;

   // State and flush index register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= DC_IDLE;
         r_flush_idx <= IDX_ZERO;
      end else begin
         r_state     <= w_next_state;
         r_flush_idx <= w_next_idx;
      end
   end

   // Next-state and output decode; bus outputs depend on state only, line pulses also on ack.
   always_comb begin
      w_next_state = r_state;
      w_next_idx   = r_flush_idx;
      w_req        = 1'b0;
      w_wr         = 1'b0;
      w_wrb        = 1'b0;
      w_line_wr    = 1'b0;
      w_clean      = 1'b0;
      w_stall      = 1'b1;
      w_done       = 1'b0;
      w_evict_idx  = r_flush_idx;
      case (r_state)
         DC_IDLE: begin
            w_evict_idx = req_index_i;
            if (cache_flush_i) begin
               w_next_state = DC_FLUSH_SCAN;
               w_next_idx   = IDX_ZERO;
            end else if (w_cpu_req && !cache_hit_i) begin
               w_next_state = cache_evict_req_i ? DC_WRITEBACK : DC_ALLOCATE;
            end else begin
               w_stall = 1'b0;
            end
         end
         DC_WRITEBACK: begin
            w_evict_idx = req_index_i;
            w_req       = 1'b1;
            w_wr        = 1'b1;
            w_wrb       = 1'b1;
            if (bus.mem2dcache_ack_i) begin
               w_clean      = 1'b1;
               w_next_state = DC_ALLOCATE;
            end else begin
               w_next_state = DC_WRITEBACK;
            end
         end
         DC_ALLOCATE: begin
            w_evict_idx = req_index_i;
            w_req       = 1'b1;
            if (bus.mem2dcache_ack_i) begin
               w_line_wr    = 1'b1;
               w_next_state = DC_IDLE;
            end else begin
               w_next_state = DC_ALLOCATE;
            end
         end
         DC_FLUSH_SCAN: begin
            if (dirty_vector[r_flush_idx]) begin
               w_next_state = DC_FLUSH_WB;
            end else if (r_flush_idx == LAST_IDX) begin
               w_next_state = DC_FLUSH_DONE;
            end else begin
               w_next_idx = r_flush_idx + IDX_ONE;
            end
         end
         DC_FLUSH_WB: begin
            w_req = 1'b1;
            w_wr  = 1'b1;
            w_wrb = 1'b1;
            // Terminate on the last index rather than counter wrap; SIZE may be below 2**INDEX_BITS.
            if (bus.mem2dcache_ack_i) begin
               w_clean = 1'b1;
               if (r_flush_idx == LAST_IDX) begin
                  w_next_state = DC_FLUSH_DONE;
               end else begin
                  w_next_idx   = r_flush_idx + IDX_ONE;
                  w_next_state = DC_FLUSH_SCAN;
               end
            end else begin
               w_next_state = DC_FLUSH_WB;
            end
         end
         DC_FLUSH_DONE: begin
            w_done       = 1'b1;
            w_next_state = DC_IDLE;
         end
         default: begin
            w_next_state = DC_IDLE;
            w_next_idx   = IDX_ZERO;
         end
      endcase
   end

   assign bus.dcache2mem_req_o = w_req;
   assign bus.dcache2mem_wr_o  = w_wr;
   assign cache_wrb_req_o      = w_wrb;
   assign cache_line_wr_o      = w_line_wr;
   assign cache_line_clean_o   = w_clean;
   assign evict_index_o        = w_evict_idx;
   assign cpu_stall_o          = w_stall;
   assign flush_done_o         = w_done;

endmodule
